result_uart_dumper: RTL and testbench

- Drives the processing core's `start_process` / `end_process` handshake from the controlling side, as the board-level stand-in for the simulation bench.
- On completion, captures the sixteen 12-bit result registers and serialises them out of the FPGA over a UART 8N1 line.
- Sits between `top`'s result outputs and the board TX pin; lets results be read back on hardware.

---
 rtl/result_uart_dumper_pkg.sv | 21 ++
 rtl/result_uart_dumper_uart_tx_byte.sv | 86 ++++++++
 rtl/result_uart_dumper.sv | 158 +++++++++++++++
 tb/tb_result_uart_dumper.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_uart_dumper_pkg.sv
// result_uart_dumper_pkg
//   Shared definitions for the result dumper.
//   - UART 8N1 framing constants.
//   - The top-level FSM state encoding.
`timescale 1ns/1ps
package result_uart_dumper_pkg;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = DATA_BITS + 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_FIN     = 3'd4
    } state_e;

endpackage

// File: rtl/result_uart_dumper_uart_tx_byte.sv
// uart_tx_byte
//   Transmits one byte as a UART 8N1 frame; each bit lasts CLK_DIV cycles.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     data     : byte to send, taken when valid && ready
//     valid    : producer has a byte
//     ready    : transmitter can take a byte this cycle
//     tx       : serial line, idles high
//   Handshake: a byte moves on a rising clk edge where valid and ready are
//   both high. ready is high while idle and also in the final cycle of a
//   stop bit, so a byte presented then starts its start bit on the very
//   next cycle with no idle gap between frames. The producer may change
//   data freely while ready is low.
`timescale 1ns/1ps
module uart_tx_byte
    import result_uart_dumper_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic                  busy_q, busy_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  bit_end;
    logic                  frame_end;

    assign bit_end   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign frame_end = busy_q && bit_end && (bit_cnt_q == 4'(FRAME_BITS - 1));
    assign ready     = !busy_q || frame_end;
    // Combinational from flops so an asynchronous reset drives the line high at once.
    assign tx        = busy_q ? shift_q[0] : STOP_BIT;

    always_comb begin
        busy_d    = busy_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;

        if (busy_q) begin
            if (bit_end) begin
                div_cnt_d = '0;
                if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                    busy_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    shift_d   = {STOP_BIT, shift_q[FRAME_BITS-1:1]};
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        // A new byte overrides the end-of-frame bookkeeping above.
        if (valid && ready) begin
            busy_d    = 1'b1;
            shift_d   = {STOP_BIT, data, START_BIT};
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/result_uart_dumper.sv
// result_uart_dumper
//   Runs the core via start_process/end_process, captures the N_REG result
//   registers when the core finishes and dumps them over UART 8N1:
//   r1 first, each register sent as the high byte {zero pad, r[REG_W-1:8]}
//   and then the low byte r[7:0].
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     go            : run request, looked at in IDLE only
//     start_process : run request to the core, held until end_process
//     end_process   : core completion level
//     results       : packed results, r1 in the LSBs
//     tx            : UART serial out
//     busy          : high outside IDLE
//     done          : one-cycle pulse after the final stop bit
//     timeout_err   : sticky, set when the core never answered
`timescale 1ns/1ps
module result_uart_dumper
    import result_uart_dumper_pkg::*;
#(
    parameter int CLK_DIV      = 434,
    parameter int N_REG        = 16,
    parameter int REG_W        = 12,
    parameter int WAIT_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    output logic                   start_process,
    input  logic                   end_process,
    input  logic [N_REG*REG_W-1:0] results,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    localparam int N_BYTES = 2 * N_REG;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam int WAIT_W  = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    state_e                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   start_q, start_d;
    logic                   timeout_q, timeout_d;
    logic [N_REG*REG_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic                   last_sent_q, last_sent_d;

    logic [REG_W-1:0]     cur_reg;
    logic [15:0]          cur_word;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    // Byte index: upper bits pick the register, LSB picks high (0) / low (1) byte.
    assign cur_reg  = buf_q[int'(byte_idx_q[IDX_W-1:1]) * REG_W +: REG_W];
    assign cur_word = 16'(cur_reg);
    assign tx_data  = byte_idx_q[0] ? cur_word[7:0] : cur_word[15:8];

    assign start_process = start_q;
    assign timeout_err   = timeout_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        start_d     = start_q;
        timeout_d   = timeout_q;
        buf_d       = buf_q;
        byte_idx_d  = byte_idx_q;
        last_sent_d = last_sent_q;
        tx_valid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d    = ST_RUN;
                    start_d    = 1'b1;
                    timeout_d  = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            ST_RUN: begin
                // Completion is tested first so it wins over a coincident timeout.
                if (end_process) begin
                    state_d = ST_CAPTURE;
                end else if (wait_cnt_q == WAIT_W'(WAIT_TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    start_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_CAPTURE: begin
                buf_d       = results;
                start_d     = 1'b0;
                byte_idx_d  = '0;
                last_sent_d = 1'b0;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (!last_sent_q) begin
                    tx_valid = 1'b1;
                    if (tx_ready) begin
                        if (byte_idx_q == IDX_W'(N_BYTES - 1)) begin
                            last_sent_d = 1'b1;
                        end else begin
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                        end
                    end
                end else if (tx_ready) begin
                    // ready rises again in the last stop-bit cycle of the final byte.
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            start_q     <= 1'b0;
            timeout_q   <= 1'b0;
            buf_q       <= '0;
            byte_idx_q  <= '0;
            last_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            start_q     <= start_d;
            timeout_q   <= timeout_d;
            buf_q       <= buf_d;
            byte_idx_q  <= byte_idx_d;
            last_sent_q <= last_sent_d;
        end
    end

    uart_tx_byte #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .data (tx_data),
        .valid(tx_valid),
        .ready(tx_ready),
        .tx   (tx)
    );

endmodule

// File: tb/tb_result_uart_dumper.sv
`timescale 1ns/1ps
module tb_result_uart_dumper;

    localparam int CLK_DIV      = 4;
    localparam int N_REG        = 16;
    localparam int REG_W        = 12;
    localparam int WAIT_TIMEOUT = 1000;
    localparam int N_BYTES      = 2 * N_REG;
    localparam int BYTE_CYC     = 10 * CLK_DIV;
    localparam int WAIT_LIMIT   = 3000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   go = 1'b0;
    logic                   end_process = 1'b0;
    logic [N_REG*REG_W-1:0] results = '0;
    logic                   start_process;
    logic                   tx;
    logic                   busy;
    logic                   done;
    logic                   timeout_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    result_uart_dumper #(
        .CLK_DIV     (CLK_DIV),
        .N_REG       (N_REG),
        .REG_W       (REG_W),
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .start_process(start_process),
        .end_process  (end_process),
        .results      (results),
        .tx           (tx),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: the byte stream a dump of 'res' must produce.
    function automatic void load_expected(input logic [N_REG*REG_W-1:0] res);
        exp_q.delete();
        for (int r = 0; r < N_REG; r++) begin
            int v;
            v = int'(res[r*REG_W +: REG_W]);
            exp_q.push_back(8'(v / 256));
            exp_q.push_back(8'(v % 256));
        end
    endfunction

    task automatic randomize_results();
        for (int r = 0; r < N_REG; r++) begin
            results[r*REG_W +: REG_W] = REG_W'($urandom_range(0, (1 << REG_W) - 1));
        end
    endtask

    // Driver: accept go, then raise end_process ep_cycle cycles into RUN
    // (ep_cycle = 0 means end_process is already high when go is taken).
    task automatic start_run(input int ep_cycle);
        if (ep_cycle == 0) end_process = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("run_start_process", start_process, 1);
        check("run_busy", busy, 1);
        check("run_timeout_clear", timeout_err, 0);
        if (ep_cycle > 0) begin
            repeat (ep_cycle - 1) tick();
            end_process = 1'b1;
        end
    endtask

    // Receiver + scoreboard: checks every tx sample of the dump against the
    // expected frames. chg_byte: overwrite results while that byte goes out.
    // abort_byte: assert rst during data bit 2 of that byte.
    task automatic rx_dump(input int chg_byte, input int abort_byte);
        int n;
        logic [BYTE_CYC-1:0] obs;
        logic [BYTE_CYC-1:0] expv;
        logic [9:0] frame;
        logic [7:0] b_exp;
        logic early_done;
        n = 0;
        early_done = 1'b0;
        while (tx !== 1'b0 && n < WAIT_LIMIT) begin
            if (n == 1) check("capture_start_high", start_process, 1);
            if (n == 2) check("send_start_low", start_process, 0);
            tick();
            n++;
        end
        check("first_start_latency", n, 3);
        end_process = 1'b0;
        if (n >= WAIT_LIMIT) return;
        for (int b = 0; b < N_BYTES; b++) begin
            b_exp = exp_q.pop_front();
            frame = {1'b1, b_exp, 1'b0};
            for (int c = 0; c < BYTE_CYC; c++) begin
                if (b == abort_byte && c == 3 * CLK_DIV + 1) begin
                    rst = 1'b1;
                    #1;
                    check("rst_tx", tx, 1);
                    check("rst_start_process", start_process, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_timeout_err", timeout_err, 0);
                    tick();
                    rst = 1'b0;
                    tick();
                    check("post_rst_tx", tx, 1);
                    exp_q.delete();
                    return;
                end
                obs[c]  = tx;
                expv[c] = frame[c / CLK_DIV];
                if (done) early_done = 1'b1;
                if (b == chg_byte && c == 0) results = '1;
                tick();
            end
            check($sformatf("byte%0d", b), 64'(obs), 64'(expv));
        end
        check("done_not_early", early_done, 0);
        check("done_pulse", done, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_dump", busy, 0);
        check("tx_idle_after_dump", tx, 1);
    endtask

    initial begin
        logic tx_ok;
        logic busy_ok;

        // Reset state
        repeat (3) tick();
        check("reset_tx", tx, 1);
        check("reset_start_process", start_process, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_timeout_err", timeout_err, 0);
        rst = 1'b0;
        tick();

        // Basic dump: r1=ABC, r2=123, others 0
        results = '0;
        results[REG_W-1:0]       = 12'hABC;
        results[2*REG_W-1:REG_W] = 12'h123;
        load_expected(results);
        check("model_first_bytes", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 32'h0ABC0123);
        start_run(50);
        rx_dump(-1, -1);

        // Timeout: end_process never arrives
        go = 1'b1;
        tick();
        go = 1'b0;
        tx_ok = 1'b1;
        busy_ok = 1'b1;
        for (int i = 0; i < WAIT_TIMEOUT; i++) begin
            if (tx !== 1'b1) tx_ok = 1'b0;
            if (busy !== 1'b1 || start_process !== 1'b1 || timeout_err !== 1'b0) busy_ok = 1'b0;
            tick();
        end
        check("timeout_tx_high", tx_ok, 1);
        check("timeout_wait_state", busy_ok, 1);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_start_low", start_process, 0);
        check("timeout_busy_low", busy, 0);
        tick();
        check("timeout_err_sticky", timeout_err, 1);

        // Data stability: results overwritten during SEND
        randomize_results();
        load_expected(results);
        start_run($urandom_range(1, 200));
        rx_dump(2, -1);

        // Reset during data bit 2 of byte 5, then a full dump again
        randomize_results();
        load_expected(results);
        start_run(10);
        rx_dump(-1, 4);
        load_expected(results);
        start_run(5);
        rx_dump(-1, -1);

        // Stale end_process: RUN lasts one cycle
        randomize_results();
        load_expected(results);
        start_run(0);
        rx_dump(-1, -1);

        // end_process on the exact timeout cycle wins
        randomize_results();
        load_expected(results);
        start_run(WAIT_TIMEOUT);
        rx_dump(-1, -1);
        check("boundary_no_timeout", timeout_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
